// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter block.
// Mode and run-state encodings used by the counter top and its bench.
package counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // The unused encoding 2'b11 folds onto WRAP.
   function automatic mode_t decode_mode(input logic [1:0] m);
      mode_t r;
      case (m)
         2'b01:   r = MODE_SAT;
         2'b10:   r = MODE_ONESHOT;
         default: r = MODE_WRAP;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/updn_counter_ctrl_if.sv
// Control/status bundle between a timing client and the up/down counter.
// The master drives controls and compare bounds; the slave returns count and flags.
interface updn_counter_ctrl_if #(
   parameter int N       = 32,
   parameter int PRESC_W = 8
);
   logic               enable;
   logic               dec;
   logic               load;
   logic [N-1:0]       load_value;
   logic [1:0]         mode;
   logic [PRESC_W-1:0] presc_div;
   logic [N-1:0]       cmp_lo;
   logic [N-1:0]       cmp_hi;
   logic [N-1:0]       count;
   logic               tc_pulse;
   logic               done;
   logic               below_lo;
   logic               above_hi;
   logic               in_window;

   modport master (
      output enable, dec, load, load_value, mode, presc_div, cmp_lo, cmp_hi,
      input  count, tc_pulse, done, below_lo, above_hi, in_window
   );

   modport slave (
      input  enable, dec, load, load_value, mode, presc_div, cmp_lo, cmp_hi,
      output count, tc_pulse, done, below_lo, above_hi, in_window
   );
endinterface

// File: rtl/updn_counter_ctrl_prescaler.sv
// Programmable tick divider: one tick every presc_div+1 cycles with run high.
// The phase is held while run is low, so a paused counter resumes mid-period.
module tick_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run_i,
   input  logic               clear_i,
   input  logic [PRESC_W-1:0] presc_div_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] presc_q, presc_d;

   // A clear (counter load) suppresses the tick of that cycle.
   assign tick_o = run_i && !clear_i && (presc_q == presc_div_i);

   always_comb begin
      presc_d = presc_q;
      if (clear_i)
         presc_d = '0;
      else if (run_i)
         presc_d = tick_o ? '0 : presc_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         presc_q <= '0;
      else
         presc_q <= presc_d;
   end

endmodule

// File: rtl/updn_counter_ctrl.sv
// N-bit up/down counter with load, prescaler, wrap/saturate/one-shot modes,
// a registered terminal-count pulse and an unsigned low/high compare window.
module updn_counter_ctrl
   import counter_pkg::*;
#(
   parameter int N       = 32,
   parameter int PRESC_W = 8
) (
   input logic               clock,
   input logic               reset,
   updn_counter_ctrl_if.slave bus
);

   state_t       state_q;
   logic [N-1:0] count_q;
   logic         tc_q;
   logic         done_q;

   logic         run;
   logic         tick;
   logic         at_term;
   mode_t        mode_eff;
   logic [N-1:0] count_step;

   assign run        = (state_q == RUN) && bus.enable;
   assign mode_eff   = decode_mode(bus.mode);
   assign at_term    = (bus.dec == DIR_DOWN) ? (count_q == '0) : (count_q == '1);
   assign count_step = (bus.dec == DIR_DOWN) ? count_q - 1'b1 : count_q + 1'b1;

   tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clock       (clock),
      .reset       (reset),
      .run_i       (run),
      .clear_i     (bus.load),
      .presc_div_i (bus.presc_div),
      .tick_o      (tick)
   );

   // Load outranks everything but reset and leaves IDLE/RUN untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.load) begin
         count_q <= bus.load_value;
         tc_q    <= 1'b0;
         if (state_q == DONE) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
         end
      end else begin
         tc_q <= tick && at_term;
         case (state_q)
            IDLE: begin
               if (bus.enable)
                  state_q <= RUN;
            end
            RUN: begin
               if (!bus.enable) begin
                  state_q <= IDLE;
               end else if (tick) begin
                  // Wrap relies on natural modulo-2^N roll-over of count_step.
                  if (!at_term || mode_eff == MODE_WRAP)
                     count_q <= count_step;
                  if (at_term && mode_eff == MODE_ONESHOT) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count     = count_q;
   assign bus.tc_pulse  = tc_q;
   assign bus.done      = done_q;
   assign bus.below_lo  = count_q < bus.cmp_lo;
   assign bus.above_hi  = count_q > bus.cmp_hi;
   assign bus.in_window = !bus.below_lo && !bus.above_hi;

endmodule

// File: tb/tb_updn_counter_ctrl.sv
// Bench for updn_counter_ctrl (N=8): constant vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_updn_counter_ctrl;

   localparam int N    = 8;
   localparam int PW   = 8;
   localparam int MAXV = (1 << N) - 1;

   logic clock = 1'b0;
   logic reset;

   updn_counter_ctrl_if #(.N(N), .PRESC_W(PW)) bus ();

   updn_counter_ctrl #(.N(N), .PRESC_W(PW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integers, state 0=idle 1=run 2=done.
   int m_count = 0;
   int m_presc = 0;
   int m_st    = 0;
   int m_tc    = 0;

   typedef struct {
      bit         rst;
      bit         en;
      bit         dec;
      bit         ld;
      logic [7:0] lv;
      logic [1:0] md;
      int         ec;
      int         etc;
      int         edn;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_step();
      bit term;
      if (reset) begin
         m_count = 0; m_presc = 0; m_st = 0; m_tc = 0;
      end else if (bus.load) begin
         m_count = int'(bus.load_value);
         m_presc = 0;
         m_tc    = 0;
         if (m_st == 2) m_st = 0;
      end else begin
         m_tc = 0;
         if (m_st == 0) begin
            if (bus.enable) m_st = 1;
         end else if (m_st == 1) begin
            if (!bus.enable) m_st = 0;
            else if (m_presc != int'(bus.presc_div)) m_presc++;
            else begin
               m_presc = 0;
               term = bus.dec ? (m_count == 0) : (m_count == MAXV);
               if (term) begin
                  m_tc = 1;
                  if (bus.mode == 2'b10) m_st = 2;
                  else if (bus.mode != 2'b01) m_count = bus.dec ? MAXV : 0;
               end else begin
                  m_count = bus.dec ? m_count - 1 : m_count + 1;
               end
            end
         end
      end
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clock);
      #1;
      chk({tag, ":count"}, int'(bus.count), m_count);
      chk({tag, ":tc"}, int'(bus.tc_pulse), m_tc);
      chk({tag, ":done"}, int'(bus.done), (m_st == 2) ? 1 : 0);
      chk({tag, ":below"}, int'(bus.below_lo), (m_count < int'(bus.cmp_lo)) ? 1 : 0);
      chk({tag, ":above"}, int'(bus.above_hi), (m_count > int'(bus.cmp_hi)) ? 1 : 0);
      chk({tag, ":inwin"}, int'(bus.in_window),
          (m_count >= int'(bus.cmp_lo) && m_count <= int'(bus.cmp_hi)) ? 1 : 0);
   endtask

   function automatic vec_t v(bit rst, bit en, bit dec, bit ld, logic [7:0] lv,
                              logic [1:0] md, int ec, int etc, int edn);
      vec_t r;
      r.rst = rst; r.en = en; r.dec = dec; r.ld = ld; r.lv = lv; r.md = md;
      r.ec = ec; r.etc = etc; r.edn = edn;
      return r;
   endfunction

   task automatic idle_inputs();
      bus.enable = 0; bus.dec = 0; bus.load = 0; bus.load_value = '0;
      bus.mode = 2'b00; bus.presc_div = '0; bus.cmp_lo = '0; bus.cmp_hi = 8'hFF;
   endtask

   initial begin
      int pulses;
      int hits;
      reset = 1'b1;
      idle_inputs();

      //           rst en dec ld  lv    md     cnt  tc done
      tbl.push_back(v(1, 0, 0, 0, 8'h00, 2'd0, 8'h00, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 8'hFE, 2'd1, 8'hFE, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd1, 8'hFE, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd1, 8'hFF, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd1, 8'hFF, 1, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd1, 8'hFF, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 2'd1, 8'hFF, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 8'h01, 2'd1, 8'h01, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd1, 8'h01, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd1, 8'h00, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd1, 8'h00, 1, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd1, 8'h00, 1, 0));
      tbl.push_back(v(0, 1, 1, 1, 8'h03, 2'd2, 8'h03, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h02, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h01, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h00, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h00, 1, 1));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h00, 0, 1));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h00, 0, 1));
      tbl.push_back(v(0, 1, 1, 1, 8'h10, 2'd2, 8'h10, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h10, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd2, 8'h0F, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 8'hFF, 2'd0, 8'hFF, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h00, 1, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h01, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 8'h40, 2'd0, 8'h40, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h41, 0, 0));
      tbl.push_back(v(1, 1, 0, 1, 8'h77, 2'd0, 8'h00, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h00, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 8'h00, 2'd0, 8'h01, 0, 0));
      tbl.push_back(v(0, 1, 1, 1, 8'h00, 2'd3, 8'h00, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd3, 8'hFF, 1, 0));
      tbl.push_back(v(0, 1, 1, 0, 8'h00, 2'd3, 8'hFE, 0, 0));

      foreach (tbl[i]) begin
         reset = tbl[i].rst; bus.enable = tbl[i].en; bus.dec = tbl[i].dec;
         bus.load = tbl[i].ld; bus.load_value = tbl[i].lv; bus.mode = tbl[i].md;
         step("tbl");
         chk($sformatf("tbl%0d:count", i), int'(bus.count), tbl[i].ec);
         chk($sformatf("tbl%0d:tc", i), int'(bus.tc_pulse), tbl[i].etc);
         chk($sformatf("tbl%0d:done", i), int'(bus.done), tbl[i].edn);
      end

      // Full wrap from reset with a tick every cycle.
      idle_inputs(); reset = 1; step("wrap_rst");
      reset = 0; bus.enable = 1; step("wrap_go");
      pulses = 0;
      for (int k = 1; k <= 256; k++) begin
         step("wrap");
         pulses += int'(bus.tc_pulse);
         if (k == 255) chk("wrap_255", int'(bus.count), 255);
      end
      chk("wrap_end_count", int'(bus.count), 0);
      chk("wrap_end_tc", int'(bus.tc_pulse), 1);
      step("wrap_after");
      pulses += int'(bus.tc_pulse);
      chk("wrap_pulses", pulses, 1);

      // Divide-by-4 with a pause that must keep the prescaler phase.
      idle_inputs(); reset = 1; step("presc_rst");
      reset = 0; bus.presc_div = 8'd3; bus.enable = 1; step("presc_go");
      for (int k = 1; k <= 3; k++) begin
         for (int j = 0; j < 3; j++) begin
            step("presc");
            chk("presc_hold", int'(bus.count), k - 1);
         end
         step("presc");
         chk("presc_tick", int'(bus.count), k);
      end
      step("presc_ph1"); step("presc_ph2");
      bus.enable = 0;
      for (int j = 0; j < 5; j++) begin
         step("presc_off");
         chk("presc_frozen", int'(bus.count), 3);
      end
      bus.enable = 1;
      step("presc_resume"); chk("presc_resume0", int'(bus.count), 3);
      step("presc_resume"); chk("presc_resume1", int'(bus.count), 3);
      step("presc_resume"); chk("presc_resume2", int'(bus.count), 4);

      // Window sweep through loads.
      idle_inputs(); bus.cmp_lo = 8'd10; bus.cmp_hi = 8'd20; bus.load = 1;
      for (int c = 8; c <= 22; c++) begin
         bus.load_value = 8'(c);
         step("win");
         chk("win_below", int'(bus.below_lo), (c < 10) ? 1 : 0);
         chk("win_above", int'(bus.above_hi), (c > 20) ? 1 : 0);
         chk("win_in", int'(bus.in_window), (c >= 10 && c <= 20) ? 1 : 0);
      end
      bus.cmp_lo = 8'd30; hits = 0;
      for (int c = 0; c <= MAXV; c++) begin
         bus.load_value = 8'(c);
         step("winx");
         hits += int'(bus.in_window);
      end
      chk("win_inverted_hits", hits, 0);

      // Randomized traffic against the model.
      idle_inputs();
      for (int k = 0; k < 3000; k++) begin
         reset      = ($urandom_range(199) == 0);
         bus.enable = ($urandom_range(7) != 0);
         if ($urandom_range(15) == 0) bus.dec = $urandom_range(1);
         if ($urandom_range(15) == 0) bus.mode = 2'($urandom_range(3));
         if ($urandom_range(31) == 0) bus.presc_div = 8'($urandom_range(3));
         bus.load = ($urandom_range(39) == 0);
         case ($urandom_range(4))
            0: bus.load_value = 8'h00;
            1: bus.load_value = 8'hFF;
            2: bus.load_value = 8'h01;
            3: bus.load_value = 8'hFE;
            default: bus.load_value = 8'($urandom);
         endcase
         if ($urandom_range(63) == 0) begin
            bus.cmp_lo = 8'($urandom);
            bus.cmp_hi = 8'($urandom);
         end
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updn_counter_ctrl.md
Name: updn_counter_ctrl

Overview:
Parametrised N-bit up/down counter with synchronous load and a programmable prescaler. It supports three count modes (wrap, saturate, one-shot) and uses a small run-control FSM. A registered terminal-count pulse and a low/high compare window replace the single fixed threshold of the previous counter generation. It drives timing/event logic in lab top levels, for example display refresh, debounce windows and timeouts.

Parameters:
N, 32, counter width in bits (N >= 2)
PRESC_W, 8, prescaler divider width in bits

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run request; 1 = count on prescaler ticks
dec  in  1  direction; 1 = decrement, 0 = increment
load  in  1  synchronous load strobe
load_value  in  N  value loaded into count
mode  in  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 treated as WRAP
presc_div  in  PRESC_W  tick every presc_div+1 enabled cycles
cmp_lo  in  N  lower window bound, unsigned
cmp_hi  in  N  upper window bound, unsigned
count  out  N  current counter value, registered
tc_pulse  out  1  one-cycle pulse on a tick at terminal value, registered
done  out  1  1 while FSM is in DONE
below_lo  out  1  count < cmp_lo (combinational from count)
above_hi  out  1  count > cmp_hi (combinational from count)
in_window  out  1  !below_lo && !above_hi

Behaviour:
- Reset values: count=0, prescaler=0, state=IDLE, tc_pulse=0, done=0.
- Flags follow count combinationally, so they reflect the new count in the same cycle it updates.
- FSM states and transitions:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> IDLE; terminal tick in ONESHOT -> DONE.
  - DONE: load=1 -> IDLE; otherwise stays, ignoring enable/dec/mode.
- Prescaler:
  - Counts only in RUN with enable=1, 0..presc_div.
  - tick=1 on the cycle prescaler==presc_div, after which the prescaler returns to 0.
  - presc_div=0 -> tick every enabled cycle.
  - Prescaler holds its value in IDLE and DONE, and clears on load.
- Count update on tick (unsigned arithmetic, width N):
  - dec=0 -> +1; dec=1 -> -1.
  - Terminal = all-ones when counting up, 0 when counting down.
  - At terminal: WRAP rolls over (max->0, 0->max); SATURATE holds; ONESHOT holds and enters DONE.
- tc_pulse:
  - Asserted the cycle after a tick taken at terminal, one cycle wide, in every mode.
  - A saturated counter pulses again on each further tick.
- load:
  - Highest priority after reset, valid in any state.
  - count<=load_value next cycle, prescaler<=0, no tick that cycle, tc_pulse<=0.
  - DONE->IDLE; IDLE/RUN state unchanged.
- dec or mode changing mid-run takes effect on the next tick. The prescaler is not disturbed.
- Window: if cmp_lo > cmp_hi, in_window is always 0, which is legal and not an error.
- Reset asserted mid-run overrides load and tick, returning everything to reset values next edge.
- mode=11 behaves identically to WRAP.

Decomposition:
- Package counter_pkg:
  - mode_t enum (MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10).
  - state_t enum (IDLE, RUN, DONE).
  - Direction constants.
- Sub-module tick_prescaler #(PRESC_W):
  - inputs clock, reset, run, clear, presc_div.
  - output tick.
- Counter datapath, FSM and compare logic stay in updn_counter_ctrl.

Test Plan:
- N=8, presc_div=0, mode WRAP, dec=0, enable=1 from reset -> count 0,1,2...; after 256 ticks count=0 and tc_pulse=1 exactly one cycle.
- presc_div=3, enable=1 -> count increments once every 4 cycles. Drop enable for 5 cycles mid-period -> count and prescaler frozen, then resume from the held phase.
- mode SAT, load_value=8'hFE, dec=0 -> FE, FF, FF, FF with a tc_pulse on each tick at FF. dec=1 from load 8'h01 -> 00, 00 with tc_pulse.
- mode ONESHOT, dec=1, load 3 -> 2, 1, 0, then done=1 and count stays 0 despite enable=1. Pulse load with 8'h10 -> done=0, IDLE, count=16, and RUN resumes since enable=1.
- cmp_lo=10, cmp_hi=20, sweep count 8..22 -> below_lo for 8,9; in_window for 10..20; above_hi for 21,22. cmp_lo=30, cmp_hi=20 -> in_window never 1.
- load and tick in the same cycle -> count=load_value, no increment. Reset asserted with load=1 -> count=0, state IDLE, tc_pulse=0.
